// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } mdu_state_t;

    // Upper opcode bit selects the divide path.
    function automatic logic is_div(input mdu_op_t op);
        return op[1];
    endfunction

    // Lower opcode bit clear means a signed operation.
    function automatic logic is_signed_op(input mdu_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step shared by multiply (shift-add, right shift) and
// divide (restoring shift-subtract, left shift) on a 2*WIDTH accumulator.
// Multiply: acc = {partial product high, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH-1:0] diff_c;

    // Compute both step variants and select by mode.
    always_comb begin
        sum_c    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                 + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        rem_sh_c = acc_i[2*WIDTH-1:WIDTH-1];
        // Difference always fits WIDTH bits when the trial subtract succeeds.
        diff_c   = rem_sh_c[WIDTH-1:0] - opnd_i;
        acc_o    = {acc_i[2*WIDTH-2:0], 1'b0};
        if (div_i) begin
            if (rem_sh_c >= {1'b0, opnd_i}) begin
                acc_o = {diff_c, acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum_c, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO pair.
// Optional macro MDU_HILO_WRITE_EN adds direct HI/LO writes (MTHI/MTLO) in IDLE.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q;
    logic               div_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    mdu_op_t            op_in_c;
    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_abs_c;
    logic [WIDTH-1:0]   b_abs_c;
    logic [2*WIDTH-1:0] acc_next_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;

    // Operand magnitudes for LOAD and sign fix-up of the raw result for FIX.
    always_comb begin
        op_in_c = mdu_op_t'(op);
        a_neg_c = is_signed_op(op_in_c) & op_a[WIDTH-1];
        b_neg_c = is_signed_op(op_in_c) & op_b[WIDTH-1];
        a_abs_c = a_neg_c ? -op_a : op_a;
        b_abs_c = b_neg_c ? -op_b : op_b;
        prod_c  = neg_lo_q ? -acc_q : acc_q;
        quo_c   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_c   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (div_q),
        .acc_o  (acc_next_c)
    );

    // Control FSM, iteration counter, sign bookkeeping and HI/LO registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef MDU_HILO_WRITE_EN
                    if (hi_we) hi_q <= wr_data;
                    if (lo_we) lo_q <= wr_data;
`endif
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    div_q <= is_div(op_in_c);
                    cnt_q <= '0;
                    if (is_div(op_in_c) && (op_b == '0)) begin
                        // Divide by zero: skip the iteration, leave HI/LO alone.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dz_q    <= 1'b1;
                    end else begin
                        state_q  <= RUN;
                        neg_lo_q <= a_neg_c ^ b_neg_c;
                        if (is_div(op_in_c)) begin
                            acc_q    <= {{WIDTH{1'b0}}, a_abs_c};
                            opnd_q   <= b_abs_c;
                            neg_hi_q <= a_neg_c;
                        end else begin
                            acc_q    <= {{WIDTH{1'b0}}, b_abs_c};
                            opnd_q   <= a_abs_c;
                            neg_hi_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_next_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    if (div_q) begin
                        hi_q <= rem_c;
                        lo_q <= quo_c;
                    end else begin
                        {hi_q, lo_q} <= prod_c;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table plus random ops against a native-arithmetic
// model through a scoreboard queue, and hand sequences for the multi-cycle corners.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

`ifdef MDU_HILO_WRITE_EN
    logic        hi_we, lo_we;
    logic [31:0] wr_data;
    logic        we8 = 1'b0;
    logic [7:0]  wr8 = 8'h00;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct { logic [1:0] op; logic [31:0] a, b, ehi, elo; logic edz; } vec_t;
    typedef struct { logic [31:0] ehi, elo; logic edz; int lat; } exp_t;
    exp_t sb[$];
    vec_t vecs[12];

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
`ifdef MDU_HILO_WRITE_EN
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
`endif
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
`ifdef MDU_HILO_WRITE_EN
        .hi_we(we8), .lo_we(we8), .wr_data(wr8),
`endif
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference results from native 64-bit arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb2, p, q, r;
        logic [63:0] up;
        sa  = longint'({{32{a[31]}}, a});
        sb2 = longint'({{32{b[31]}}, b});
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = sa * sb2; {eh, el} = p; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; {eh, el} = up; end
            2'b10: begin q = sa / sb2; r = sa % sb2; el = q[31:0]; eh = r[31:0]; end
            default: begin el = a / b; eh = a % b; end
        endcase
    endtask

    // Drive one op, push its expectation, follow it to done and compare.
    task automatic run_op(input vec_t v, input int mid_n, input bit done_start);
        exp_t e;
        int n, busy_err, cnt;
        sb.push_back('{v.ehi, v.elo, v.edz, (v.edz ? 2 : 35)});
        op = v.op; op_a = v.a; op_b = v.b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        busy_err = 0;
        while (done !== 1'b1 && n <= 40) begin
            if (busy !== 1'b1) busy_err++;
            if (n == 2) begin op_a = $urandom; op_b = $urandom; op = 2'($urandom); end
            if (n == mid_n) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        e = sb.pop_front();
        check("latency", 64'(n), 64'(e.lat));
        check("done", {63'h0, done}, 64'h1);
        check("busy_in_done", {63'h0, busy}, 64'h0);
        check("busy_while_running", 64'(busy_err), 64'h0);
        check("hi", {32'h0, hi}, {32'h0, e.ehi});
        check("lo", {32'h0, lo}, {32'h0, e.elo});
        check("div_zero", {63'h0, div_zero}, {63'h0, e.edz});
        if (done_start) start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", {63'h0, done}, 64'h0);
        if (done_start) begin
            cnt = 0;
            repeat (40) begin
                if (busy === 1'b1 || done === 1'b1) cnt++;
                tick();
            end
            check("ignored_start_quiet", 64'(cnt), 64'h0);
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo);
        int n;
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        while (done8 !== 1'b1 && n <= 20) begin
            tick();
            n++;
        end
        check("w8_latency", 64'(n), 64'd11);
        check("w8_hi", {56'h0, hi8}, {56'h0, ehi});
        check("w8_lo", {56'h0, lo8}, {56'h0, elo});
        tick();
    endtask

    initial begin
        vec_t v;
        logic [31:0] eh, el;
        int cnt;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'd5,        32'd0,        32'h00000012, 32'h34567800, 1'b1};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'h00000012, 32'h34567800, 1'b1};
        vecs[10] = '{OP_MULT,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
`ifdef MDU_HILO_WRITE_EN
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outputs", {hi, lo}, 64'h0);
        check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
        check("reset_w8", {45'h0, hi8, lo8, busy8, done8, dz8}, 64'h0);

        foreach (vecs[i]) run_op(vecs[i], 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            v.op = 2'(i % 4);
            v.a  = $urandom;
            v.b  = $urandom;
            if (v.op[1] && (i % 8) >= 4) v.b = v.b >> 24;
            if (v.b == 0) v.b = 32'd3;
            model(v.op, v.a, v.b, eh, el);
            v.ehi = eh; v.elo = el; v.edz = 1'b0;
            run_op(v, 0, 1'b0);
        end

        // Start mid-RUN and start in the DONE cycle are both ignored.
        run_op('{OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0}, 7, 1'b1);

        // Abort in RUN cycle 10 with a stray start beforehand.
        op = OP_MULTU; op_a = 32'h0000FFFF; op_b = 32'h00010001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 12; n++) begin
            if (n == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_flags", {62'h0, busy, done}, 64'h0);
        cnt = 0;
        repeat (45) begin
            if (busy === 1'b1 || done === 1'b1) cnt++;
            tick();
        end
        check("abort_quiet", 64'(cnt), 64'h0);
        run_op('{OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0}, 0, 1'b0);

        run8(OP_MULT,  8'h80, 8'h80, 8'h40, 8'h00);
        run8(OP_DIV,   8'hF9, 8'h02, 8'hFF, 8'hFD);
        run8(OP_DIVU,  8'hFF, 8'h10, 8'h0F, 8'h0F);
        run8(OP_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);

`ifdef MDU_HILO_WRITE_EN
        hi_we = 1'b1; wr_data = 32'hAA;
        tick();
        hi_we = 1'b0;
        check("mthi_idle", {32'h0, hi}, 64'hAA);
        lo_we = 1'b1; wr_data = 32'h55;
        tick();
        lo_we = 1'b0;
        check("mtlo_idle", {32'h0, lo}, 64'h55);
        op = OP_MULTU; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hi_we = 1'b1; wr_data = 32'hBB;
        tick();
        hi_we = 1'b0;
        check("mthi_busy_ignored", {32'h0, hi}, 64'hAA);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("after_busy_write", {hi, lo}, 64'h0000000000000006);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
